tempo_sequencer: RTL and testbench

//  Controls the half-beat tick generator. Accepts tempo change requests through a valid/ready handshake.

---
 rtl/tempo_pkg.sv | 28 ++
 rtl/tempo_sequencer_step_counter.sv | 48 ++++
 rtl/tempo_sequencer.sv | 123 ++++++++++++
 tb/tb_tempo_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared definitions for the tempo sequencer: FSM state encoding, load-sequence
// length, tempo width and the tempo clamp helper.
package tempo_pkg;

    localparam int BPM_W       = 8;
    localparam int LOAD_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_BAR,
        ST_LOAD
    } state_t;

    function automatic logic [BPM_W-1:0] clamp_bpm(
        input logic [BPM_W-1:0] value,
        input logic [BPM_W-1:0] lo,
        input logic [BPM_W-1:0] hi
    );
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/tempo_sequencer_step_counter.sv
// Turns half-beat ticks into eighth-note step indices, with step/downbeat pulses
// one cycle after the tick. The first tick after priming is cleared lands on step 0.
module step_counter #(
    parameter int STEPS_PER_BAR = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             enable,
    input  logic                             clear_primed,
    output logic [$clog2(STEPS_PER_BAR)-1:0] step_idx,
    output logic                             step_pulse,
    output logic                             downbeat,
    output logic                             bar_wrap
);

    localparam int STEP_W = $clog2(STEPS_PER_BAR);

    logic              primed;
    logic [STEP_W-1:0] next_idx;

    assign next_idx = primed ? step_idx + 1'b1 : '0;

    // A processed tick that lands on step 0 marks the bar boundary.
    assign bar_wrap = enable && tick && !clear_primed && (next_idx == '0);

    // Clearing the primed flag wins over a coincident tick, which is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_idx   <= '0;
            step_pulse <= 1'b0;
            downbeat   <= 1'b0;
            primed     <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            downbeat   <= 1'b0;
            if (clear_primed) begin
                primed <= 1'b0;
            end else if (enable && tick) begin
                primed     <= 1'b1;
                step_idx   <= next_idx;
                step_pulse <= 1'b1;
                downbeat   <= (next_idx == '0);
            end
        end
    end

endmodule

// File: rtl/tempo_sequencer.sv
// Tempo request handshake, clamp and 3-cycle generator load sequence, plus step counting.
// Define QUANTIZE_TEMPO_EN to defer tempo changes made while running to the next bar.
module tempo_sequencer
    import tempo_pkg::*;
#(
    parameter int STEPS_PER_BAR = 8,
    parameter int MIN_BPM       = 30,
    parameter int MAX_BPM       = 240,
    parameter int RESET_BPM     = 120
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [BPM_W-1:0]                 bpm_req,
    input  logic                             bpm_req_valid,
    output logic                             bpm_req_ready,
    input  logic                             tick_in,
    output logic [BPM_W-1:0]                 gen_bpm,
    output logic                             gen_load_bpm,
    output logic                             gen_go,
    output logic [$clog2(STEPS_PER_BAR)-1:0] step_idx,
    output logic                             step_pulse,
    output logic                             downbeat,
    output logic                             busy
);

    state_t           state;
    state_t           next_state;
    logic [1:0]       load_cnt;
    logic [BPM_W-1:0] pend_bpm;
    logic [BPM_W-1:0] req_clamped;
    logic [BPM_W-1:0] load_val;
    logic             accept;
    logic             load_start;
    logic             defer;
    logic             resync;
    logic             bar_wrap;
    logic             count_en;

    assign req_clamped = clamp_bpm(bpm_req, BPM_W'(MIN_BPM), BPM_W'(MAX_BPM));
    assign accept      = bpm_req_valid && bpm_req_ready;
    assign count_en    = ((state == ST_RUN) || (state == ST_WAIT_BAR)) && run;

    always_comb begin
        next_state    = state;
        load_start    = 1'b0;
        load_val      = req_clamped;
        defer         = 1'b0;
        resync        = 1'b0;
        bpm_req_ready = (state == ST_IDLE) || (state == ST_RUN);
        busy          = (state == ST_WAIT_BAR) || (state == ST_LOAD);
        gen_load_bpm  = (state == ST_LOAD);
        gen_go        = (state == ST_RUN) || (state == ST_WAIT_BAR);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_LOAD;
                    load_start = 1'b1;
                end else if (run) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
`ifdef QUANTIZE_TEMPO_EN
                    next_state = ST_WAIT_BAR;
                    defer      = 1'b1;
`else
                    next_state = ST_LOAD;
                    load_start = 1'b1;
                    resync     = 1'b1;
`endif
                end else if (!run) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT_BAR: begin
                if (!run || bar_wrap) begin
                    next_state = ST_LOAD;
                    load_start = 1'b1;
                    load_val   = pend_bpm;
                end
            end
            ST_LOAD: begin
                if (load_cnt == 2'(LOAD_CYCLES - 1))
                    next_state = run ? ST_RUN : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // gen_bpm takes its new value on the edge entering LOAD so it is stable throughout the load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            gen_bpm  <= BPM_W'(RESET_BPM);
            pend_bpm <= BPM_W'(RESET_BPM);
        end else begin
            state    <= next_state;
            load_cnt <= (state == ST_LOAD) ? load_cnt + 2'd1 : 2'd0;
            if (load_start)
                gen_bpm <= load_val;
            if (defer)
                pend_bpm <= req_clamped;
        end
    end

    step_counter #(
        .STEPS_PER_BAR (STEPS_PER_BAR)
    ) u_step_counter (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick_in),
        .enable       (count_en),
        .clear_primed (!run || resync),
        .step_idx     (step_idx),
        .step_pulse   (step_pulse),
        .downbeat     (downbeat),
        .bar_wrap     (bar_wrap)
    );

endmodule

// File: tb/tb_tempo_sequencer.sv
// Bench for tempo_sequencer: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the sequencer.
module tb_tempo_sequencer;

    localparam int STEPS = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_LOAD = 3;
`ifdef QUANTIZE_TEMPO_EN
    localparam bit QUANT = 1'b1;
`else
    localparam bit QUANT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, run, bpm_req_valid, tick_in;
    logic [7:0] bpm_req;
    logic       bpm_req_ready, gen_load_bpm, gen_go, step_pulse, downbeat, busy;
    logic [7:0] gen_bpm;
    logic [2:0] step_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model of the sequencer as seen at its outputs.
    int m_mode, m_left, m_step, m_bpm, m_pend;
    bit m_primed, m_pulse, m_down;
    bit model_valid = 1'b0;

    always #10 clk = ~clk;

    tempo_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .bpm_req       (bpm_req),
        .bpm_req_valid (bpm_req_valid),
        .bpm_req_ready (bpm_req_ready),
        .tick_in       (tick_in),
        .gen_bpm       (gen_bpm),
        .gen_load_bpm  (gen_load_bpm),
        .gen_go        (gen_go),
        .step_idx      (step_idx),
        .step_pulse    (step_pulse),
        .downbeat      (downbeat),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ru, input bit v, input int req, input bit t);
        reset         = r;
        run           = ru;
        bpm_req_valid = v;
        bpm_req       = 8'(req);
        tick_in       = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int clampRef(input int v);
        if (v < 30) return 30;
        if (v > 240) return 240;
        return v;
    endfunction

    function automatic void startLoad(input int v);
        m_mode = M_LOAD;
        m_left = 3;
        m_bpm  = v;
    endfunction

    task automatic modelStep();
        bit acc, cnt, wrap;
        if (!reset) begin
            m_mode = M_IDLE; m_left = 0; m_step = 0; m_bpm = 120; m_pend = 120;
            m_primed = 0; m_pulse = 0; m_down = 0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        acc  = bpm_req_valid && (m_mode == M_IDLE || m_mode == M_RUN);
        cnt  = (m_mode == M_RUN || m_mode == M_WAIT) && run;
        wrap = 0;
        m_pulse = 0;
        m_down  = 0;
        if (!run)
            m_primed = 0;
        else if (acc && m_mode == M_RUN && !QUANT)
            m_primed = 0;
        else if (cnt && tick_in) begin
            m_step   = m_primed ? (m_step + 1) % STEPS : 0;
            m_primed = 1;
            m_pulse  = 1;
            m_down   = (m_step == 0);
            wrap     = m_down;
        end
        case (m_mode)
            M_IDLE: begin
                if (acc) startLoad(clampRef(int'(bpm_req)));
                else if (run) m_mode = M_RUN;
            end
            M_RUN: begin
                if (acc) begin
                    if (QUANT) begin
                        m_mode = M_WAIT;
                        m_pend = clampRef(int'(bpm_req));
                    end else begin
                        startLoad(clampRef(int'(bpm_req)));
                    end
                end else if (!run) begin
                    m_mode = M_IDLE;
                end
            end
            M_WAIT: if (!run || wrap) startLoad(m_pend);
            default: begin
                m_left--;
                if (m_left == 0) m_mode = run ? M_RUN : M_IDLE;
            end
        endcase
    endtask

    // Per-cycle compare: advance the model on the edge, then check outputs just after it.
    always @(posedge clk) begin
        modelStep();
        #1;
        if (model_valid) begin
            checkOutput("ready", bpm_req_ready, (m_mode == M_IDLE || m_mode == M_RUN));
            checkOutput("busy", busy, (m_mode == M_WAIT || m_mode == M_LOAD));
            checkOutput("load_bpm", gen_load_bpm, (m_mode == M_LOAD));
            checkOutput("go", gen_go, (m_mode == M_RUN || m_mode == M_WAIT));
            checkOutput("gen_bpm", gen_bpm, m_bpm);
            checkOutput("step_idx", step_idx, m_step);
            checkOutput("step_pulse", step_pulse, m_pulse);
            checkOutput("downbeat", downbeat, m_down);
        end
    end

    initial begin
        bit vld, rn, rs, t, acc;
        int rq;

        $display("[TB] reset and basic counting");
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_rst_bpm", gen_bpm, 120);
        checkOutput("t1_rst_ready", bpm_req_ready, 1);
        checkOutput("t1_rst_go", gen_go, 0);
        checkOutput("t1_rst_step", step_idx, 0);
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
            checkOutput("t1_step", step_idx, i % 8);
            checkOutput("t1_down", downbeat, (i == 0 || i == 8) ? 1 : 0);
            checkOutput("t1_pulse", step_pulse, 1);
        end
        checkOutput("t1_go", gen_go, 1);
        checkOutput("t1_bpm", gen_bpm, 120);
        applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] idle tempo load");
        applyStimulus(1, 0, 1, 90, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_ready", bpm_req_ready, 0);
            checkOutput("t2_load", gen_load_bpm, 1);
            checkOutput("t2_bpm", gen_bpm, 90);
            applyStimulus(1, 0, 0, 0, 0);
        end
        checkOutput("t2_load_done", gen_load_bpm, 0);
        checkOutput("t2_ready_back", bpm_req_ready, 1);
        checkOutput("t2_model_bpm", m_bpm, 90);

        $display("[TB] clamp");
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("t3_clamp_lo", gen_bpm, 30);
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 255, 0);
        checkOutput("t3_clamp_hi", gen_bpm, 240);
        checkOutput("t3_model_hi", m_bpm, 240);
        repeat (3) applyStimulus(1, 0, 0, 0, 0);

        applyStimulus(1, 1, 0, 0, 0);
`ifdef QUANTIZE_TEMPO_EN
        $display("[TB] quantized tempo change");
        repeat (4) applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t4_step3", step_idx, 3);
        applyStimulus(1, 1, 1, 60, 0);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_noload", gen_load_bpm, 0);
        checkOutput("t4_bpm_old", gen_bpm, 240);
        for (int i = 4; i < 8; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
            checkOutput("t4_step", step_idx, i);
            checkOutput("t4_wait_noload", gen_load_bpm, 0);
        end
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t4_wrap_step", step_idx, 0);
        checkOutput("t4_wrap_down", downbeat, 1);
        checkOutput("t4_load", gen_load_bpm, 1);
        checkOutput("t4_bpm", gen_bpm, 60);
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t4_go", gen_go, 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t4_next_step", step_idx, 1);
        checkOutput("t4_next_down", downbeat, 0);
`else
        $display("[TB] immediate tempo change");
        repeat (6) applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t5_step5", step_idx, 5);
        applyStimulus(1, 1, 1, 60, 0);
        checkOutput("t5_load", gen_load_bpm, 1);
        checkOutput("t5_go", gen_go, 0);
        checkOutput("t5_bpm", gen_bpm, 60);
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t5_go_back", gen_go, 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t5_resync_step", step_idx, 0);
        checkOutput("t5_resync_down", downbeat, 1);
`endif
        applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] reset during load, run falling with tick");
        applyStimulus(1, 0, 1, 200, 0);
        checkOutput("t6_bpm", gen_bpm, 200);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_abort_load", gen_load_bpm, 0);
        checkOutput("t6_abort_bpm", gen_bpm, 120);
        applyStimulus(1, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t6_step2", step_idx, 2);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t6_nopulse", step_pulse, 0);
        checkOutput("t6_held", step_idx, 2);
        checkOutput("t6_go", gen_go, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("t6_restart_step", step_idx, 0);
        checkOutput("t6_restart_down", downbeat, 1);

        $display("[TB] random stimulus");
        vld = 0;
        rq  = 0;
        rn  = 1;
        for (int c = 0; c < 4000; c++) begin
            rs = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) rn = !rn;
            if (!vld && $urandom_range(0, 24) == 0) begin
                vld = 1;
                case ($urandom_range(0, 3))
                    0:       rq = 0;
                    1:       rq = 255;
                    default: rq = int'($urandom_range(0, 255));
                endcase
            end
            t   = ($urandom_range(0, 3) == 0);
            acc = vld && rs && (m_mode == M_IDLE || m_mode == M_RUN);
            applyStimulus(rs, rn, vld, rq, t);
            if (acc || !rs) vld = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
